// File: rtl/mux_arb_pkg.sv
// Shared defaults and FSM encoding for the two-lane round-robin byte arbiter.
package mux_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int PTR_W      = $clog2(DEPTH_DEF);

    // IDLE: output stage empty; SEND: output stage holds a word (valid_out=1)
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small per-lane FIFO. The head word is read straight from registered state,
// so a push is never visible to a pop on the same edge. Pushes into a full
// FIFO are ignored here; flagging them is the parent's job.
module byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              f2,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              wr_en;
    logic              rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Storage array: written at the tail, no reset needed
    always_ff @(posedge f2) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH
    always_ff @(posedge f2 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler sharing one registered byte output between two lanes.
// Output handshake: a word transfers on a rising edge where valid_out=1 and
// ready_out=1; while valid_out=1 and ready_out=0, data_out/sel/valid_out hold.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              f2,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              valid_in1,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              sel,
    output logic              full0,
    output logic              full1,
    output logic              err0,
    output logic              err1
);

    arb_state_t        state;
    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic              empty0;
    logic              empty1;
    logic              push0;
    logic              push1;
    logic              pop0;
    logic              pop1;
    logic              load;
    logic              gnt_any;
    logic              gnt_lane;
    logic [DATA_W-1:0] head;

    // Pushes are judged against the pre-edge full flag
    assign push0 = valid_in0 && !full0;
    assign push1 = valid_in1 && !full1;

    byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .f2    (f2),
        .reset (reset),
        .push  (push0),
        .din   (data_in0),
        .pop   (pop0),
        .dout  (dout0),
        .empty (empty0),
        .full  (full0)
    );

    byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .f2    (f2),
        .reset (reset),
        .push  (push1),
        .din   (data_in1),
        .pop   (pop1),
        .dout  (dout1),
        .empty (empty1),
        .full  (full1)
    );

    // Grant: under contention the lane other than the last one served wins
    always_comb begin
        load     = !valid_out || ready_out;
        gnt_any  = 1'b0;
        gnt_lane = 1'b0;
        if (load) begin
            if (!empty0 && !empty1) begin
                gnt_any  = 1'b1;
                gnt_lane = !sel;
            end else if (!empty0) begin
                gnt_any  = 1'b1;
                gnt_lane = 1'b0;
            end else if (!empty1) begin
                gnt_any  = 1'b1;
                gnt_lane = 1'b1;
            end
        end
    end

    assign pop0 = gnt_any && !gnt_lane;
    assign pop1 = gnt_any && gnt_lane;
    assign head = gnt_lane ? dout1 : dout0;

    // Output FSM with registered data_out/valid_out/sel
    always_ff @(posedge f2 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_out  <= '0;
            valid_out <= 1'b0;
            sel       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        data_out  <= head;
                        sel       <= gnt_lane;
                        valid_out <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (ready_out) begin
                        if (gnt_any) begin
                            data_out  <= head;
                            sel       <= gnt_lane;
                            valid_out <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flags: set by a push that arrives while the lane is full
    always_ff @(posedge f2 or posedge reset) begin
        if (reset) begin
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            if (valid_in0 && full0) err0 <= 1'b1;
            if (valid_in1 && full1) err1 <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed stimulus, expected {sel,data} words queued
// as stimulus is issued, checked by a monitor on each accepted output word.
module tb_mux_rr_arbiter;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              f2;
    logic              reset;
    logic [DATA_W-1:0] data_in0;
    logic              valid_in0;
    logic [DATA_W-1:0] data_in1;
    logic              valid_in1;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              sel;
    logic              full0;
    logic              full1;
    logic              err0;
    logic              err1;

    logic [DATA_W:0] exp_q[$];
    int              n_cmp;
    int              n_err;

    mux_rr_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .f2        (f2),
        .reset     (reset),
        .data_in0  (data_in0),
        .valid_in0 (valid_in0),
        .data_in1  (data_in1),
        .valid_in1 (valid_in1),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sel       (sel),
        .full0     (full0),
        .full1     (full1),
        .err0      (err0),
        .err1      (err1)
    );

    // Clock
    initial f2 = 1'b0;
    always #5 f2 = ~f2;

    task automatic tick();
        @(posedge f2);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_word(input logic s, input logic [DATA_W-1:0] d);
        exp_q.push_back({s, d});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every word accepted on the coming edge is checked against the queue
    always @(negedge f2) begin
        if (!reset && valid_out && ready_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got sel=%0d data=%0h, expected none", sel, data_out);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                if ({sel, data_out} !== e) begin
                    n_err++;
                    $display("FAIL out_word: got sel=%0d data=%0h expected sel=%0d data=%0h",
                             sel, data_out, e[DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        data_in0  = '0;
        valid_in0 = 1'b0;
        data_in1  = '0;
        valid_in1 = 1'b0;
        ready_out = 1'b0;

        // Reset then idle
        tick();
        tick();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_sel", 32'(sel), 1);
        chk("rst_flags", {28'd0, full0, full1, err0, err1}, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("idle_valid", 32'(valid_out), 0);

        // Reset asserted while SEND holds a word
        data_in0  = 8'h55;
        valid_in0 = 1'b1;
        tick();
        valid_in0 = 1'b0;
        tick();
        chk("midsend_valid", 32'(valid_out), 1);
        chk("midsend_data", 32'(data_out), 32'h55);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid_out), 0);
        chk("async_rst_data", 32'(data_out), 32'h00);
        chk("async_rst_sel", 32'(sel), 1);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", 32'(valid_out), 0);

        // Single lane, A1..A3 back to back
        ready_out = 1'b1;
        expect_word(1'b0, 8'hA1);
        expect_word(1'b0, 8'hA2);
        expect_word(1'b0, 8'hA3);
        data_in0  = 8'hA1;
        valid_in0 = 1'b1;
        tick();
        chk("lat_edge1_valid", 32'(valid_out), 0);
        data_in0 = 8'hA2;
        tick();
        chk("lat_edge2_data", 32'(data_out), 32'hA1);
        chk("lat_edge2_valid", 32'(valid_out), 1);
        data_in0 = 8'hA3;
        tick();
        chk("edge3_data", 32'(data_out), 32'hA2);
        valid_in0 = 1'b0;
        tick();
        chk("edge4_data", 32'(data_out), 32'hA3);
        tick();
        chk("edge5_valid", 32'(valid_out), 0);
        chk("edge5_data_hold", 32'(data_out), 32'hA3);
        drain(10);

        // Contention with backpressure on the first word
        do_reset();
        ready_out = 1'b0;
        expect_word(1'b0, 8'h10);
        expect_word(1'b1, 8'h20);
        expect_word(1'b0, 8'h11);
        expect_word(1'b1, 8'h21);
        data_in0  = 8'h10;
        data_in1  = 8'h20;
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        tick();
        data_in0 = 8'h11;
        data_in1 = 8'h21;
        tick();
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_data", 32'(data_out), 32'h10);
            chk("bp_sel", 32'(sel), 0);
            chk("bp_valid", 32'(valid_out), 1);
        end
        ready_out = 1'b1;
        tick();
        chk("bp_release_data", 32'(data_out), 32'h20);
        chk("bp_release_sel", 32'(sel), 1);
        drain(10);
        tick();
        chk("cont_idle", 32'(valid_out), 0);

        // Overflow on lane 1
        ready_out = 1'b0;
        valid_in1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in1 = 8'h30 + 8'(i);
            tick();
            if (i == 3) chk("ovf_not_full_yet", 32'(full1), 0);
        end
        chk("ovf_full1", 32'(full1), 1);
        chk("ovf_err1_clear", 32'(err1), 0);
        chk("ovf_head", 32'(data_out), 32'h30);
        data_in1 = 8'h35;
        tick();
        valid_in1 = 1'b0;
        chk("ovf_err1_set", 32'(err1), 1);
        chk("ovf_err0_clear", 32'(err0), 0);
        for (int i = 0; i < 5; i++) expect_word(1'b1, 8'h30 + 8'(i));
        ready_out = 1'b1;
        drain(20);
        tick();
        chk("ovf_err1_sticky", 32'(err1), 1);
        chk("ovf_full1_after", 32'(full1), 0);
        chk("ovf_idle", 32'(valid_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin scheduler that shares the 2:1 byte mux datapath between two independent requesters (lane 0, lane 1).
- Each lane has a small input FIFO. The arbiter picks one non-empty lane per cycle and drives a registered output stage with a valid/ready handshake toward the consumer.
- It exports the mux select it used, so the existing mux/synth pair can be checked against it in the bench.

Parameters:
- DATA_W, 8, width of data_in0/data_in1/data_out.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.

Ports:
- f2  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in0  in  DATA_W  lane 0 write data.
- valid_in0  in  1  lane 0 push request.
- data_in1  in  DATA_W  lane 1 write data.
- valid_in1  in  1  lane 1 push request.
- ready_out  in  1  consumer accepts data_out this cycle.
- data_out  out  DATA_W  registered output byte.
- valid_out  out  1  data_out holds a word.
- sel  out  1  lane of the word currently or last presented (0 or 1).
- full0  out  1  lane 0 FIFO holds DEPTH entries.
- full1  out  1  lane 1 FIFO holds DEPTH entries.
- err0  out  1  sticky: lane 0 push dropped.
- err1  out  1  sticky: lane 1 push dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFOs empty; data_out=0, valid_out=0.
  - sel=1, so lane 0 wins the first contention.
  - full0/1=0, err0/1=0, FSM in IDLE.
- Push:
  - A push on lane N is accepted when valid_inN=1 and fullN=0, evaluated on the pre-edge count.
  - A push while fullN=1 is dropped, even if a pop occurs on the same edge, and errN sets. errN clears only on reset.
- FIFO count range is 0..DEPTH; pointers wrap modulo DEPTH. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Load condition: load = (valid_out==0) or (ready_out==1).
- Grant, evaluated when load=1:
  - Both lanes non-empty: grant lane !sel.
  - Exactly one lane non-empty: grant that lane.
  - Neither lane non-empty: no grant.
- On a grant, on the same edge:
  - Pop the head of the granted FIFO into data_out.
  - sel <= granted lane.
  - valid_out <= 1.
- FSM states:
  - IDLE (valid_out=0): grant goes to SEND, otherwise stay.
  - SEND (valid_out=1):
    - ready_out=0: hold data_out, valid_out and sel stable (no change permitted).
    - ready_out=1 and grant: stay in SEND with the new word, giving back-to-back throughput of 1 word/cycle.
    - ready_out=1 and no grant: go to IDLE, valid_out <= 0, data_out holds its last value.
- Latency: a word pushed at edge k into an empty system, with the output free, appears with valid_out=1 after edge k+1. The FIFO is read from registered state, with no bypass.
- Push is not forwarded: a push on an empty FIFO on the same edge as a load is not visible to that load.
- fullN reflects the post-edge count.
- Order within a lane is strict FIFO. With both lanes backlogged the output alternates lanes every accepted word.

Decomposition:
- Package mux_arb_pkg:
  - DATA_W and DEPTH defaults.
  - Localparam PTR_W = log2(DEPTH).
  - FSM state encoding: IDLE=1'b0, SEND=1'b1.
- Sub-module byte_fifo (parameters DATA_W, DEPTH):
  - Ports: f2, reset, push, din, pop, dout, empty, full.
  - Instantiated twice.
  - Overflow detection lives in the parent.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, no pushes -> valid_out=0, data_out=8'h00, sel=1, full/err all 0; assert reset mid-SEND -> outputs clear before the next edge.
- Single lane: push 8'hA1, 8'hA2, 8'hA3 on lane 0 on consecutive edges, ready_out=1 -> data_out A1,A2,A3 on edges 2,3,4 with sel=0 throughout; valid_out drops after edge 5.
- Contention: preload lane 0 {8'h10,8'h11} and lane 1 {8'h20,8'h21}, then ready_out=1 -> output sequence 10,20,11,21 with sel 0,1,0,1.
- Backpressure: while valid_out=1 with data_out=8'h10, hold ready_out=0 for 3 cycles -> data_out, sel and valid_out unchanged; next word appears one edge after ready_out returns to 1.
- Overflow: ready_out=0, push 5 words (8'h30..8'h34) on lane 1 with DEPTH=4 -> the first word goes to data_out, full1=1 after the fifth push, and err1 stays 0.
  - Then push 8'h35 -> dropped, err1=1.
  - Then drain -> 30,31,32,33,34 and err1 stays 1.
- Equivalence: drive the mux and synth inputs from data_in* and sel in the existing bench -> mux/synth data_out match data_out on every cycle with valid_out=1.
